// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and constants for the pmem bus controller slice
//
// Purpose : State encoding, default widths and port identifiers shared by
//           pmem_bus_ctrl, pmem_rr_arb and the pmem_dff memory.
// Contents: PMEM_ADDR_W / PMEM_DATA_W  default address / data widths
//           PORT_FETCH / PORT_DATA     port identifiers used by the arbiter
//           pmem_state_t               controller FSM states
//           rr_pick()                  two-way round-robin decision
package pmem_pkg;

   localparam int PMEM_ADDR_W = 8;
   localparam int PMEM_DATA_W = 8;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } pmem_state_t;

   // A lone request always wins; on a tie the port that did not win last time
   // is chosen, so neither requester can be starved.
   function automatic logic rr_pick(input logic req_fetch,
                                    input logic req_data,
                                    input logic last_grant);
      logic pick;
      if (req_fetch && req_data) begin
         pick = ~last_grant;
      end else if (req_data) begin
         pick = PORT_DATA;
      end else begin
         pick = PORT_FETCH;
      end
      return pick;
   endfunction

endpackage

// File: rtl/pmem_rr_arb.sv
// rtl/pmem_rr_arb.sv - two-way round-robin arbiter between fetch and data ports
//
// Purpose : Chooses which requester the controller serves next and remembers
//           the last winner so ties alternate.
// Ports   : clock        in   rising-edge clock
//           reset_n      in   asynchronous active-low reset (last grant -> fetch)
//           req_fetch    in   fetch port request
//           req_data     in   data port request
//           update       in   strobe: the current grant is being taken
//           grant_valid  out  at least one request is pending
//           grant        out  winning port (PORT_FETCH / PORT_DATA)
module pmem_rr_arb
   import pmem_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic req_fetch,
   input  logic req_data,
   input  logic update,
   output logic grant_valid,
   output logic grant
);

   logic last_q;

   always_comb begin
      grant_valid = req_fetch | req_data;
      grant       = rr_pick(req_fetch, req_data, last_q);
   end

   // Reset to "fetch" so the data port wins the very first tie.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= PORT_FETCH;
      end else if (update) begin
         last_q <= grant;
      end
   end

endmodule

// File: rtl/pmem_bus_ctrl.sv
// rtl/pmem_bus_ctrl.sv - fetch/data bus controller in front of pmem_dff
//
// Purpose : Arbitrates instruction fetches (code space, read-only) and
//           loads/stores (data space) onto a single pmem_dff, one transaction
//           at a time, with a watchdog that aborts a memory that never answers.
// Ports   : clock, reset_n                 clock / async active-low reset
//           f_req, f_addr                   fetch request and code address
//           f_ack, f_rdata                  fetch acknowledge pulse and byte
//           d_req, d_write, d_addr, d_wdata data request, direction, operands
//           d_ack, d_rdata                  data acknowledge pulse and byte
//           err                             pulses with the ack of an aborted txn
//           mem_select, mem_addr,
//           mem_data_in, mem_type_data,
//           mem_write                       drive pmem_dff select/addr/data_in/
//                                           memory_type_data/write
//           mem_data_out, mem_data_ready    pmem_dff data_out / data_ready
module pmem_bus_ctrl
   import pmem_pkg::*;
#(
   parameter int ADDR_W  = PMEM_ADDR_W,
   parameter int DATA_W  = PMEM_DATA_W,
   parameter int TIMEOUT = 31
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              mem_select,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_type_data,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_data_ready
);

   // TIMEOUT is at most 255, so eight bits always reach it without wrapping.
   localparam int CNT_W = 8;

   pmem_state_t      state_q;
   pmem_state_t      state_d;
   logic             port_q;
   logic             err_q;
   logic [CNT_W-1:0] wd_cnt_q;

   logic             grant_valid;
   logic             grant;
   logic             take;
   logic             finish;
   logic             abort;
   logic             timeout_hit;
   logic             grant_is_data;
   logic [DATA_W-1:0] resp_data;

   pmem_rr_arb u_arb (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_fetch   (f_req),
      .req_data    (d_req),
      .update      (take),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign grant_is_data = (grant == PORT_DATA);
   assign timeout_hit   = (wd_cnt_q == CNT_W'(TIMEOUT));

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A memory answer in the same cycle the watchdog expires still counts as
   // a normal completion: the data is valid, so it is not thrown away.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      finish  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               take    = 1'b1;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem_data_ready) begin
               finish  = 1'b1;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               abort   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode straight from registered state, so they are glitch-free
   // and drop the instant reset is asserted.
   assign mem_select = (state_q == ST_ACCESS);
   assign f_ack      = (state_q == ST_RESP) && (port_q == PORT_FETCH);
   assign d_ack      = (state_q == ST_RESP) && (port_q == PORT_DATA);
   assign err        = (state_q == ST_RESP) && err_q;

   // Stores and aborted transactions return zero rather than whatever the
   // memory happens to drive on data_out.
   assign resp_data = (finish && !mem_write) ? mem_data_out : '0;

   // ---------------------------------------------------------------------
   // Datapath: memory-side operands, watchdog, captured read data
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         port_q        <= PORT_FETCH;
         err_q         <= 1'b0;
         wd_cnt_q      <= '0;
         mem_addr      <= '0;
         mem_data_in   <= '0;
         mem_type_data <= 1'b0;
         mem_write     <= 1'b0;
         f_rdata       <= '0;
         d_rdata       <= '0;
      end else begin
         // Memory-side operands only ever change here, on IDLE->ACCESS, so
         // they stay put through ACCESS and RESP.
         if (take) begin
            port_q        <= grant;
            mem_type_data <= grant_is_data;
            mem_write     <= grant_is_data && d_write;
            mem_addr      <= grant_is_data ? d_addr : f_addr;
            mem_data_in   <= grant_is_data ? d_wdata : '0;
            err_q         <= 1'b0;
            wd_cnt_q      <= '0;
         end

         if (state_q == ST_ACCESS) begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
         end

         if (finish || abort) begin
            err_q <= abort;
            if (port_q == PORT_DATA) begin
               d_rdata <= resp_data;
            end else begin
               f_rdata <= resp_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_pmem_bus_ctrl.sv
// tb/tb_pmem_bus_ctrl.sv - scoreboard bench for pmem_bus_ctrl with a pmem_dff-style memory
module tb_pmem_bus_ctrl;
   import pmem_pkg::*;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 31;
   localparam int ACK_LIMIT = 300;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          f_req, d_req, d_write;
   logic [AW-1:0] f_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          f_ack, d_ack, err;
   logic [DW-1:0] f_rdata, d_rdata;
   logic          mem_select, mem_type_data, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out = '0;
   logic          mem_data_ready = 1'b0;

   always #5 clock = ~clock;

   pmem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .f_req          (f_req),
      .f_addr         (f_addr),
      .f_ack          (f_ack),
      .f_rdata        (f_rdata),
      .d_req          (d_req),
      .d_write        (d_write),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_ack          (d_ack),
      .d_rdata        (d_rdata),
      .err            (err),
      .mem_select     (mem_select),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_type_data  (mem_type_data),
      .mem_write      (mem_write),
      .mem_data_out   (mem_data_out),
      .mem_data_ready (mem_data_ready)
   );

   // ------------------------------------------------------------------
   // Memory stand-in: two byte spaces, ready 'lat' cycles after the first
   // edge that sees select (ready cycle k = lat + 2 counting from request).
   // ------------------------------------------------------------------
   logic [DW-1:0] code_mem [256];
   logic [DW-1:0] data_mem [256] = '{default: '0};
   int  lat = 0;
   bit  hang = 1'b0;
   bit  rand_lat = 1'b0;
   int  rlat = 0;
   int  mcnt = 0;

   always @(posedge clock) begin
      mem_data_ready <= 1'b0;
      if (!mem_select || hang) begin
         mcnt <= 0;
      end else if (!mem_data_ready) begin
         if (mcnt >= (rand_lat ? rlat : lat)) begin
            mem_data_ready <= 1'b1;
            mcnt <= 0;
            rlat = $urandom_range(0, 3);
            if (mem_type_data) begin
               if (mem_write) begin
                  data_mem[mem_addr] <= mem_data_in;
                  mem_data_out <= ~mem_data_in;
               end else begin
                  mem_data_out <= data_mem[mem_addr];
               end
            end else begin
               mem_data_out <= code_mem[mem_addr];
            end
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Reference model and scoreboard
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   logic [DW-1:0] ref_code [256];
   logic [DW-1:0] ref_data [256];
   exp_t fq[$];
   exp_t dq[$];
   logic order_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   f_acks = 0;
   int   d_acks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   exp_t me;
   always @(negedge clock) begin
      if (f_ack) begin
         f_acks++;
         order_q.push_back(PORT_FETCH);
         check("f_ack_expected", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) begin
            me = fq.pop_front();
            check("f_rdata", 32'(f_rdata), 32'(me.data));
            check("f_err", 32'(err), 32'(me.err));
         end
      end
      if (d_ack) begin
         d_acks++;
         order_q.push_back(PORT_DATA);
         check("d_ack_expected", 32'(dq.size() != 0), 32'd1);
         if (dq.size() != 0) begin
            me = dq.pop_front();
            check("d_rdata", 32'(d_rdata), 32'(me.data));
            check("d_err", 32'(err), 32'(me.err));
         end
      end
      if (f_ack || d_ack) begin
         check("single_ack", 32'(f_ack && d_ack), 32'd0);
      end
   end

   // Memory-side watcher: select gap and operand stability through RESP.
   bit          prev_sel = 1'b0;
   bit          seen_sel = 1'b0;
   int          low_cnt = 0;
   logic [17:0] held;
   always @(negedge clock) begin
      if (mem_select) begin
         if (!prev_sel) begin
            if (seen_sel) check("select_gap_ge2", 32'(low_cnt >= 2), 32'd1);
            seen_sel = 1'b1;
            held = {mem_addr, mem_data_in, mem_type_data, mem_write};
         end else begin
            check("mem_side_stable", 32'({mem_addr, mem_data_in, mem_type_data, mem_write}), 32'(held));
         end
         low_cnt = 0;
      end else begin
         if (prev_sel && reset_n) begin
            check("mem_side_held_resp", 32'({mem_addr, mem_data_in, mem_type_data, mem_write}), 32'(held));
         end
         low_cnt++;
      end
      prev_sel = mem_select;
   end

   // ------------------------------------------------------------------
   // Drivers: called at posedge+1, return at posedge+1 with req dropped
   // ------------------------------------------------------------------
   task automatic wait_ack(input bit port, output int n);
      bit got = 1'b0;
      n = 0;
      while (!got && n < ACK_LIMIT) begin
         @(negedge clock);
         if (port ? d_ack : f_ack) got = 1'b1;
         else n++;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_wait port %0d: no ack within %0d cycles, required one", port, ACK_LIMIT);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic fetch_op(input logic [AW-1:0] a, input bit to, output int n);
      exp_t e;
      e.data = to ? '0 : ref_code[a];
      e.err  = to;
      fq.push_back(e);
      f_addr = a;
      f_req  = 1'b1;
      wait_ack(PORT_FETCH, n);
      f_req  = 1'b0;
   endtask

   task automatic data_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int n);
      exp_t e;
      e.data = w ? '0 : ref_data[a];
      e.err  = 1'b0;
      if (w) ref_data[a] = wd;
      dq.push_back(e);
      d_write = w;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1'b1;
      wait_ack(PORT_DATA, n);
      d_req   = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, n2, acks0, g;
      bit seen;
      f_req = 0; d_req = 0; f_addr = '0; d_addr = '0; d_write = 0; d_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         code_mem[i] = '0; ref_code[i] = '0; ref_data[i] = '0;
      end

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_f_ack", 32'(f_ack), 0);
      check("rst_d_ack", 32'(d_ack), 0);
      check("rst_err", 32'(err), 0);
      check("rst_mem_select", 32'(mem_select), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_data_in", 32'(mem_data_in), 0);
      check("rst_mem_type", 32'(mem_type_data), 0);
      check("rst_mem_write", 32'(mem_write), 0);
      check("rst_f_rdata", 32'(f_rdata), 0);
      check("rst_d_rdata", 32'(d_rdata), 0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Directed: spaces are separate; lat 0 -> ready in cycle 2, ack in cycle 3
      lat = 0;
      data_op(1'b1, 8'd5, 8'd42, n);
      check("store_ack_cycle", 32'(n), 32'd3);
      fetch_op(8'd5, 1'b0, n);
      check("fetch_ack_cycle", 32'(n), 32'd3);
      data_op(1'b0, 8'd5, 8'd0, n);
      data_op(1'b0, 8'd6, 8'd0, n);
      code_mem[5] = 8'd99;
      ref_code[5] = 8'd99;
      fetch_op(8'd5, 1'b0, n);
      data_op(1'b0, 8'd5, 8'd0, n);
      lat = 2;
      fetch_op(8'd5, 1'b0, n);
      check("fetch_ack_cycle_lat2", 32'(n), 32'd5);

      // Tie after reset: data, fetch, data, fetch
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      lat = 0;
      order_q.delete();
      fork
         begin
            fetch_op(8'd1, 1'b0, n);
            fetch_op(8'd2, 1'b0, n);
         end
         begin
            data_op(1'b0, 8'd5, 8'd0, n2);
            data_op(1'b1, 8'd3, 8'd77, n2);
         end
      join
      check("tie_grant_count", 32'(order_q.size()), 32'd4);
      if (order_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_grant_%0d", i), 32'(order_q[i]), 32'((i % 2 == 0) ? PORT_DATA : PORT_FETCH));
         end
      end

      // Back-to-back fetches: lat 1 -> ready cycle 3, ack cycle 4, period 5
      lat = 1;
      acks0 = d_acks;
      for (int i = 0; i < 4; i++) begin
         fetch_op(8'(i + 4), 1'b0, n);
         check("b2b_fetch_ack_cycle", 32'(n), 32'd4);
      end
      check("b2b_data_idle", 32'(d_acks - acks0), 32'd0);

      // Watchdog: memory never answers, ack + err in cycle TIMEOUT+2
      lat = 0;
      fetch_op(8'd5, 1'b0, n);
      hang = 1'b1;
      fetch_op(8'd5, 1'b1, n);
      check("timeout_ack_cycle", 32'(n), 32'(TO + 2));
      hang = 1'b0;
      fetch_op(8'd5, 1'b0, n);
      check("after_timeout_ack_cycle", 32'(n), 32'd3);

      // Reset mid-ACCESS: select drops at once, held load re-issued once
      lat = 6;
      acks0 = d_acks;
      fork
         data_op(1'b0, 8'd5, 8'd0, n);
         begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clock);
               if (mem_select) seen = 1'b1;
            end
            check("rst_mid_select_seen", 32'(seen), 32'd1);
            @(posedge clock);
            #2;
            reset_n = 1'b0;
            #1;
            check("rst_mid_select_low", 32'(mem_select), 0);
            check("rst_mid_d_ack", 32'(d_ack), 0);
            check("rst_mid_f_rdata", 32'(f_rdata), 0);
            check("rst_mid_mem_addr", 32'(mem_addr), 0);
            @(posedge clock);
            @(posedge clock);
            #1;
            reset_n = 1'b1;
         end
      join
      check("rst_mid_ack_count", 32'(d_acks - acks0), 32'd1);

      // Randomized traffic on both ports with random memory latency
      for (int i = 0; i < 256; i++) begin
         ref_code[i] = 8'($urandom);
         code_mem[i] = ref_code[i];
      end
      rand_lat = 1'b1;
      fork
         for (int i = 0; i < 24; i++) begin
            fetch_op(8'($urandom_range(0, 15)), 1'b0, n);
            g = $urandom_range(0, 3);
            if (g > 0) begin
               repeat (g) @(posedge clock);
               #1;
            end
         end
         for (int j = 0; j < 24; j++) begin
            int g2;
            data_op(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), n2);
            g2 = $urandom_range(0, 3);
            if (g2 > 0) begin
               repeat (g2) @(posedge clock);
               #1;
            end
         end
      join
      repeat (5) @(posedge clock);
      #1;
      check("fq_drained", 32'(fq.size()), 0);
      check("dq_drained", 32'(dq.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
